// File: rtl/block_storage_if.sv
// Byte-load bus into the header store and its parallel chunk views.
// The loader drives the write side; the SHA-256 core consumes the chunk views.
interface block_storage_if;
    logic             i_data_en;
    logic [7:0]       i_data;
    logic [6:0]       i_data_sel;
    logic [63:0][7:0] chunk_1;
    logic [15:0][7:0] chunk_2;
    logic [3:0][7:0]  difficulty;

    modport master (
        output i_data_en,
        output i_data,
        output i_data_sel,
        input  chunk_1,
        input  chunk_2,
        input  difficulty
    );

    modport slave (
        input  i_data_en,
        input  i_data,
        input  i_data_sel,
        output chunk_1,
        output chunk_2,
        output difficulty
    );
endinterface

// File: rtl/block_storage.sv
// 80-byte Bitcoin block header store, loaded one byte per cycle.
// It exposes the header as two hash chunks plus the nBits difficulty field.
module block_storage (
    input  logic           clk,
    input  logic           n_rst,
    block_storage_if.slave bus
);
    localparam logic [6:0] NUM_BYTES = 7'd80;

    logic [79:0][7:0] bytes_r;
    logic             wr_en_s;

    // Qualify the write: indices 80..127 are silently ignored.
    always_comb begin
        wr_en_s = 1'b0;
        if (bus.i_data_en && (bus.i_data_sel < NUM_BYTES)) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Header byte storage; reset clears the whole header and discards a partial load.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bytes_r <= '0;
        end else if (wr_en_s) begin
            bytes_r[bus.i_data_sel] <= bus.i_data;
        end else begin
            bytes_r <= bytes_r;
        end
    end

    // Difficulty aliases the same registers as chunk_2[8..11].
    assign bus.chunk_1    = bytes_r[63:0];
    assign bus.chunk_2    = bytes_r[79:64];
    assign bus.difficulty = bytes_r[75:72];
endmodule

// File: tb/tb_block_storage.sv
// Self-checking bench for block_storage: directed sequences, a vector table,
// and random writes compared against a byte-array model of the header.
module tb_block_storage;
    logic clk;
    logic n_rst;
    block_storage_if bus ();

    block_storage dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [80];
    int n_checks;
    int n_fail;

    typedef struct {
        logic       en;
        logic [6:0] sel;
        logic [7:0] data;
        int         chk;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic check8(string name, logic [7:0] act, logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_all(string name);
        logic [639:0] exp;
        logic [31:0]  dexp;
        for (int i = 0; i < 80; i++) exp[8*i +: 8] = mem[i];
        dexp = {mem[75], mem[74], mem[73], mem[72]};
        n_checks++;
        if ({bus.chunk_2, bus.chunk_1} !== exp) begin
            n_fail++;
            $display("FAIL %s storage: got %h want %h", name, {bus.chunk_2, bus.chunk_1}, exp);
        end
        n_checks++;
        if (bus.difficulty !== dexp) begin
            n_fail++;
            $display("FAIL %s difficulty: got %h want %h", name, bus.difficulty, dexp);
        end
    endtask

    function automatic logic [7:0] dut_byte(int idx);
        logic [639:0] flat;
        flat = {bus.chunk_2, bus.chunk_1};
        return flat[8*idx +: 8];
    endfunction

    // Drive one cycle of inputs, then apply the storage rule to the model.
    task automatic write_byte(logic en, logic [6:0] sel, logic [7:0] d);
        @(negedge clk);
        bus.i_data_en  = en;
        bus.i_data_sel = sel;
        bus.i_data     = d;
        @(posedge clk);
        #1;
        if (en && sel < 7'd80) mem[sel] = d;
    endtask

    task automatic mid_cycle_reset(string name);
        #2;
        n_rst = 1'b0;
        #1;
        for (int i = 0; i < 80; i++) mem[i] = 8'h00;
        check_all(name);
        @(negedge clk);
        bus.i_data_en  = 1'b1;
        bus.i_data_sel = 7'd3;
        bus.i_data     = 8'h55;
        @(posedge clk);
        #1;
        check_all({name, "_write_blocked"});
        @(negedge clk);
        bus.i_data_en = 1'b0;
        n_rst = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        vecs[0] = '{1'b0, 7'd5,   8'hAA, 5,  8'h05};
        vecs[1] = '{1'b0, 7'd5,   8'hAA, 5,  8'h05};
        vecs[2] = '{1'b0, 7'd5,   8'hAA, 6,  8'h06};
        vecs[3] = '{1'b1, 7'd80,  8'hFF, 79, 8'h4F};
        vecs[4] = '{1'b1, 7'd127, 8'hFF, 0,  8'h00};
        vecs[5] = '{1'b1, 7'd73,  8'h11, 73, 8'h11};
        vecs[6] = '{1'b1, 7'd73,  8'h22, 73, 8'h22};
        vecs[7] = '{1'b1, 7'd75,  8'h3C, 75, 8'h3C};

        for (int i = 0; i < 80; i++) mem[i] = 8'h00;
        n_rst          = 1'b0;
        bus.i_data_en  = 1'b0;
        bus.i_data_sel = 7'd0;
        bus.i_data     = 8'h00;
        #3;
        check_all("reset");
        @(negedge clk);
        n_rst = 1'b1;

        // Sequential load: byte i = i.
        for (int i = 0; i < 80; i++) begin
            write_byte(1'b1, 7'(i), 8'(i));
            check_all("seq_load");
        end
        check8("seq_chunk1_0", bus.chunk_1[0], 8'd0);
        check8("seq_chunk1_63", bus.chunk_1[63], 8'd63);
        check8("seq_chunk2_15", bus.chunk_2[15], 8'd79);
        n_checks++;
        if (bus.difficulty !== {8'd75, 8'd74, 8'd73, 8'd72}) begin
            n_fail++;
            $display("FAIL seq_difficulty: got %h want %h", bus.difficulty, {8'd75, 8'd74, 8'd73, 8'd72});
        end

        // Vector table: gating, out of range, overwrite, difficulty tap.
        for (int v = 0; v < 8; v++) begin
            write_byte(vecs[v].en, vecs[v].sel, vecs[v].data);
            check8("vec_byte", dut_byte(vecs[v].chk), vecs[v].exp);
            check_all("vec_model");
        end
        check8("diff_tap_73", bus.difficulty[1], 8'h22);
        check8("chunk2_tap_73", bus.chunk_2[9], 8'h22);
        check8("diff_tap_75", bus.difficulty[3], 8'h3C);

        // Reverse-order load: byte i = 0xFF - i.
        for (int i = 79; i >= 0; i--) begin
            write_byte(1'b1, 7'(i), 8'(8'hFF - 8'(i)));
        end
        check_all("rev_load");
        check8("rev_byte0", bus.chunk_1[0], 8'hFF);
        check8("rev_byte79", bus.chunk_2[15], 8'hB0);

        mid_cycle_reset("reset_after_load");

        // Random writes including disabled and out-of-range cycles.
        for (int r = 0; r < 300; r++) begin
            write_byte($urandom_range(0, 3) != 0, 7'($urandom_range(0, 127)), 8'($urandom));
            check_all("random");
            if (r == 150) mid_cycle_reset("reset_mid_random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
